// File: rtl/sega_joy_scanner.sv
// Multi-port Sega DB9 joystick scanner: drives the shared select line through an
// 8-step sequence per frame and publishes one atomically committed word per port.
module sega_joy_scanner #(
    parameter int NUM_PORTS   = 2,
    parameter int CLK_DIV     = 352,
    parameter int FRAME_STEPS = 256
) (
    input  logic                      clk_i,
    input  logic                      res_n_i,
    input  logic                      enable_i,
    input  logic [NUM_PORTS-1:0]      joy_up_i,
    input  logic [NUM_PORTS-1:0]      joy_down_i,
    input  logic [NUM_PORTS-1:0]      joy_left_i,
    input  logic [NUM_PORTS-1:0]      joy_right_i,
    input  logic [NUM_PORTS-1:0]      joy_p6_i,
    input  logic [NUM_PORTS-1:0]      joy_p9_i,
    output logic                      joy_p7_o,
    output logic [12*NUM_PORTS-1:0]   joy_s_o,
    output logic [2*NUM_PORTS-1:0]    pad_type_o,
    output logic                      frame_o
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // One spare bit so step[STEP_W-1:3] exists even when FRAME_STEPS == 8.
    localparam int STEP_W = $clog2(FRAME_STEPS + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAME_STEPS - 1);

    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic [STEP_W-1:0]    step;
    logic                 in_scan;
    logic                 hold_idle;

    logic [11:0]          shadow [NUM_PORTS];
    logic [NUM_PORTS-1:0] six_flag;
    logic [NUM_PORTS-1:0] md_flag;

    always_comb begin
        tick      = (div_cnt == DIV_LAST);
        in_scan   = (step[STEP_W-1:3] == '0);
        hold_idle = (step == '0) && !enable_i;
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            step       <= '0;
            joy_p7_o   <= 1'b1;
            joy_s_o    <= '1;
            pad_type_o <= '0;
            frame_o    <= 1'b0;
            six_flag   <= '0;
            md_flag    <= '0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                shadow[i] <= '1;
            end
        end else begin
            frame_o <= 1'b0;
            if (tick && !hold_idle) begin
                step <= (step == STEP_LAST) ? '0 : step + 1'b1;
                if (in_scan) begin
                    case (step[2:0])
                        3'd0: joy_p7_o <= 1'b0;
                        3'd1: joy_p7_o <= 1'b1;
                        3'd2: begin
                            joy_p7_o <= 1'b0;
                            six_flag <= '0;
                            md_flag  <= '0;
                            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                                shadow[i][3:0] <= {joy_right_i[i], joy_left_i[i],
                                                   joy_down_i[i], joy_up_i[i]};
                                shadow[i][5:4] <= {joy_p9_i[i], joy_p6_i[i]};
                            end
                        end
                        3'd3: begin
                            joy_p7_o <= 1'b1;
                            // L and R both low with select low identifies a Mega Drive pad.
                            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                                if (!joy_left_i[i] && !joy_right_i[i]) begin
                                    shadow[i][7:6] <= {joy_p9_i[i], joy_p6_i[i]};
                                    md_flag[i]     <= 1'b1;
                                end else begin
                                    shadow[i][7:4] <= {2'b11, joy_p9_i[i], joy_p6_i[i]};
                                end
                            end
                        end
                        3'd4: joy_p7_o <= 1'b0;
                        3'd5: begin
                            joy_p7_o <= 1'b1;
                            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                                if (!joy_up_i[i] && !joy_down_i[i] &&
                                    !joy_left_i[i] && !joy_right_i[i]) begin
                                    six_flag[i] <= 1'b1;
                                end
                            end
                        end
                        3'd6: begin
                            joy_p7_o <= 1'b0;
                            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                                shadow[i][11:8] <= six_flag[i] ?
                                    {joy_right_i[i], joy_left_i[i], joy_down_i[i], joy_up_i[i]} :
                                    4'b1111;
                            end
                        end
                        default: begin
                            joy_p7_o <= 1'b1;
                            frame_o  <= 1'b1;
                            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                                joy_s_o[12*i +: 12]   <= shadow[i];
                                pad_type_o[2*i +: 2]  <= six_flag[i] ? 2'b10 :
                                                         md_flag[i]  ? 2'b01 : 2'b00;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sega_joy_scanner.sv
// Directed bench for sega_joy_scanner with a select-driven pad model per port
// (static pins, 3-button or 6-button) and a table of expected committed words.
module tb_sega_joy_scanner;

    localparam int NP = 2;

    logic            clk_i = 1'b0;
    logic            res_n_i;
    logic            enable_i;
    logic [NP-1:0]   joy_up, joy_down, joy_left, joy_right, joy_p6, joy_p9;
    logic            joy_p7_o;
    logic [12*NP-1:0] joy_s_o;
    logic [2*NP-1:0] pad_type_o;
    logic            frame_o;

    always #5 clk_i = ~clk_i;

    sega_joy_scanner #(
        .NUM_PORTS   (NP),
        .CLK_DIV     (4),
        .FRAME_STEPS (16)
    ) dut (
        .clk_i       (clk_i),
        .res_n_i     (res_n_i),
        .enable_i    (enable_i),
        .joy_up_i    (joy_up),
        .joy_down_i  (joy_down),
        .joy_left_i  (joy_left),
        .joy_right_i (joy_right),
        .joy_p6_i    (joy_p6),
        .joy_p9_i    (joy_p9),
        .joy_p7_o    (joy_p7_o),
        .joy_s_o     (joy_s_o),
        .pad_type_o  (pad_type_o),
        .frame_o     (frame_o)
    );

    // Pad model: mode 0 = static pins {p9,p6,R,L,D,U}; 1 = 3-button; 2 = 6-button.
    // btn is active-low in MXYZ SACB RLDU order.
    int unsigned mode [NP];
    logic [11:0] btn  [NP];
    logic [5:0]  stat [NP];

    int   lows   = 0;
    int   hi_cnt = 0;
    logic p7_d   = 1'b1;

    always @(posedge clk_i) begin
        p7_d   <= joy_p7_o;
        hi_cnt <= joy_p7_o ? hi_cnt + 1 : 0;
        if (p7_d && !joy_p7_o) lows <= lows + 1;
        else if (hi_cnt > 12)  lows <= 0;
    end

    always_comb begin
        joy_up = '1; joy_down = '1; joy_left = '1; joy_right = '1; joy_p6 = '1; joy_p9 = '1;
        for (int p = 0; p < NP; p++) begin
            if (mode[p] == 0) begin
                {joy_p9[p], joy_p6[p], joy_right[p], joy_left[p], joy_down[p], joy_up[p]} = stat[p];
            end else if (joy_p7_o) begin
                if (mode[p] == 2 && lows == 3)
                    {joy_right[p], joy_left[p], joy_down[p], joy_up[p]} = btn[p][11:8];
                else
                    {joy_right[p], joy_left[p], joy_down[p], joy_up[p]} = btn[p][3:0];
                joy_p6[p] = btn[p][4];
                joy_p9[p] = btn[p][5];
            end else begin
                if (mode[p] == 2 && lows == 3)
                    {joy_right[p], joy_left[p], joy_down[p], joy_up[p]} = 4'b0000;
                else
                    {joy_right[p], joy_left[p], joy_down[p], joy_up[p]} = {2'b00, btn[p][1:0]};
                joy_p6[p] = btn[p][6];
                joy_p9[p] = btn[p][7];
            end
        end
    end

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Returns the number of rising edges until frame_o is seen, or -1 on timeout.
    task automatic wait_frame(input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk_i);
            #1;
            n++;
        end while (!frame_o && n < budget);
        if (!frame_o) n = -1;
    endtask

    typedef struct {
        int unsigned mode0;
        logic [11:0] btn0;
        logic [5:0]  stat0;
        int unsigned mode1;
        logic [11:0] btn1;
        logic [5:0]  stat1;
        logic [23:0] exp_s;
        logic [3:0]  exp_t;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n;
        int frames;
        int p7_lows;

        vecs[0] = '{0, 12'hFFF, 6'b100111, 0, 12'hFFF, 6'h3F, 24'hFFF_FE7, 4'b0000}; // Master System
        vecs[1] = '{1, 12'hFBF, 6'h3F,     0, 12'hFFF, 6'h3F, 24'hFFF_FBF, 4'b0001}; // 3-button A
        vecs[2] = '{2, 12'h3FF, 6'h3F,     1, 12'hF7F, 6'h3F, 24'hF7F_3FF, 4'b0110}; // mixed ports
        vecs[3] = '{2, 12'h7FF, 6'h3F,     0, 12'hFFF, 6'h3F, 24'hFFF_7FF, 4'b0010}; // 6-button M
        vecs[4] = '{0, 12'hFFF, 6'h3F,     0, 12'hFFF, 6'h3F, 24'hFFF_FFF, 4'b0000}; // hot-swap to idle MS
        vecs[5] = '{1, 12'hFDE, 6'h3F,     2, 12'h000, 6'h3F, 24'h000_FDE, 4'b1001}; // U+C, all pressed

        res_n_i  = 1'b0;
        enable_i = 1'b1;
        for (int p = 0; p < NP; p++) begin
            mode[p] = 0;
            btn[p]  = 12'hFFF;
            stat[p] = 6'($urandom);
        end

        repeat (10) @(negedge clk_i);
        check("rst_s",     32'(joy_s_o),    32'hFF_FFFF);
        check("rst_type",  32'(pad_type_o), 32'h0);
        check("rst_p7",    32'(joy_p7_o),   32'h1);
        check("rst_frame", 32'(frame_o),    32'h0);

        res_n_i = 1'b1;
        wait_frame(100, n);
        check("first_frame_cycles", n, 32);

        for (int i = 0; i < 6; i++) begin
            mode[0] = vecs[i].mode0; btn[0] = vecs[i].btn0; stat[0] = vecs[i].stat0;
            mode[1] = vecs[i].mode1; btn[1] = vecs[i].btn1; stat[1] = vecs[i].stat1;
            wait_frame(100, n);
            check($sformatf("row%0d_period", i), n, 64);
            check($sformatf("row%0d_s", i),    32'(joy_s_o),    32'(vecs[i].exp_s));
            check($sformatf("row%0d_type", i), 32'(pad_type_o), 32'(vecs[i].exp_t));
        end

        // Drop enable just after the step-3 tick: the frame must still commit.
        repeat (48) @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        wait_frame(100, n);
        check("disable_late_commit", n, 16);

        frames  = 0;
        p7_lows = 0;
        repeat (200) begin
            @(posedge clk_i);
            #1;
            if (frame_o)   frames++;
            if (!joy_p7_o) p7_lows++;
        end
        check("disabled_frames",  frames,  0);
        check("disabled_p7_lows", p7_lows, 0);
        check("disabled_hold_s",  32'(joy_s_o), 32'h000_FDE);

        enable_i = 1'b1;
        wait_frame(100, n);
        check("reenable_commit", n, 32);
        check("reenable_s",      32'(joy_s_o),    32'h000_FDE);
        check("reenable_type",   32'(pad_type_o), 32'h9);

        // Step-4 tick is the 13th tick after commit; reset lands mid-frame.
        repeat (52) @(posedge clk_i);
        #1;
        check("step4_p7", 32'(joy_p7_o), 32'h0);
        res_n_i = 1'b0;
        #1;
        check("midrst_p7",    32'(joy_p7_o),   32'h1);
        check("midrst_s",     32'(joy_s_o),    32'hFF_FFFF);
        check("midrst_type",  32'(pad_type_o), 32'h0);
        check("midrst_frame", 32'(frame_o),    32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
